// File: rtl/mac_tx_framer.sv
// Frames a 4-byte-per-beat payload stream into XGMII-style lane words: start/preamble/SFD, payload, zero pad, CRC-32 FCS, terminate, IFG idles.
// Latency: the word for state S is registered and appears on o_w* one enabled cycle after S is evaluated.
// Backpressure: o_tready is high only in DATA; the framer never stalls for the downstream buffer.
module mac_tx_framer #(
   parameter int N_CHANNELS  = 4,
   parameter int W_BYTE      = 8,
   parameter int MIN_PAYLOAD = 60,
   parameter int IFG_WORDS   = 3
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_clk_en,
   input  logic                         i_clr,
   input  logic                         i_tvalid,
   output logic                         o_tready,
   input  logic [N_CHANNELS*W_BYTE-1:0] i_tdata,
   input  logic [N_CHANNELS-1:0]        i_tkeep,
   input  logic                         i_tlast,
   output logic                         o_wen,
   output logic [N_CHANNELS-1:0]        o_wctrl,
   output logic [N_CHANNELS*W_BYTE-1:0] o_wdata,
   output logic                         o_underrun
);

   localparam int W_WORD = N_CHANNELS * W_BYTE;
   localparam int W_N    = $clog2(N_CHANNELS + 1);
   localparam int W_IFG  = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;

   localparam logic [W_BYTE-1:0] C_START = W_BYTE'(8'hFB);
   localparam logic [W_BYTE-1:0] C_TERM  = W_BYTE'(8'hFD);
   localparam logic [W_BYTE-1:0] C_IDLE  = W_BYTE'(8'h07);
   localparam logic [W_BYTE-1:0] C_PRE   = W_BYTE'(8'h55);
   localparam logic [W_BYTE-1:0] C_SFD   = W_BYTE'(8'hD5);

   localparam logic [W_WORD-1:0] PRE0_WORD = {{(N_CHANNELS-1){C_PRE}}, C_START};
   localparam logic [W_WORD-1:0] PRE1_WORD = {C_SFD, {(N_CHANNELS-1){C_PRE}}};
   localparam logic [W_WORD-1:0] TERM_WORD = {{(N_CHANNELS-1){C_IDLE}}, C_TERM};
   localparam logic [W_WORD-1:0] IDLE_WORD = {N_CHANNELS{C_IDLE}};

   typedef enum logic [3:0] {
      S_IDLE, S_PRE0, S_PRE1, S_DATA, S_PAD, S_FCS, S_TAIL, S_TERM, S_IFG
   } state_t;

   state_t              state_q;
   logic [15:0]         count_q;
   logic [31:0]         crc_q;
   logic [W_N-1:0]      tail_n_q;
   logic [W_IFG-1:0]    ifg_q;
   logic                wen_q;
   logic [N_CHANNELS-1:0] wctrl_q;
   logic [W_WORD-1:0]   wdata_q;
   logic                underrun_q;

   // Reflected CRC-32 (0xEDB88320) over the lanes selected by mask, lane 0 first.
   function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                              input logic [W_WORD-1:0] data,
                                              input logic [N_CHANNELS-1:0] mask);
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (mask[i]) begin
            c = c ^ 32'(data[W_BYTE*i +: W_BYTE]);
            for (int b = 0; b < 8; b++) begin
               c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
         end
      end
      return c;
   endfunction

   // Byte counter add that sticks at 0xFFFF instead of wrapping.
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [W_N-1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + 17'(b);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [W_N-1:0]        beat_n;
   logic                  beat_short;
   logic [N_CHANNELS-1:0] beat_mask;
   logic [W_WORD-1:0]     beat_word;
   logic [31:0]           beat_crc;
   logic [31:0]           beat_fcs;
   logic [15:0]           beat_count;
   state_t                beat_next;
   logic [31:0]           fcs_cur;
   logic [31:0]           pad_crc;
   logic [W_WORD-1:0]     tail_word;
   logic [N_CHANNELS-1:0] tail_ctrl;

   assign o_tready = (state_q == S_DATA);

   // Decode the current beat: zero-fill short frames, or splice leading FCS bytes into a partial last beat.
   always_comb begin
      beat_n     = i_tlast ? W_N'($countones(i_tkeep)) : W_N'(N_CHANNELS);
      beat_short = ({1'b0, count_q} + 17'(beat_n)) < 17'(MIN_PAYLOAD);
      beat_word  = '0;
      beat_mask  = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (i < int'(beat_n)) begin
            beat_word[W_BYTE*i +: W_BYTE] = i_tdata[W_BYTE*i +: W_BYTE];
            beat_mask[i] = 1'b1;
         end else if (beat_short) begin
            beat_mask[i] = 1'b1;
         end
      end
      beat_crc = crc_update(crc_q, beat_word, beat_mask);
      beat_fcs = ~beat_crc;
      if (!beat_short) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            if (i >= int'(beat_n)) begin
               beat_word[W_BYTE*i +: W_BYTE] = beat_fcs[W_BYTE*(i - int'(beat_n)) +: W_BYTE];
            end
         end
      end
      beat_count = sat_add(count_q, beat_short ? W_N'(N_CHANNELS) : beat_n);
      if (!i_tlast) begin
         beat_next = S_DATA;
      end else if (beat_short) begin
         beat_next = (({1'b0, count_q} + 17'(N_CHANNELS)) >= 17'(MIN_PAYLOAD)) ? S_FCS : S_PAD;
      end else if (int'(beat_n) == N_CHANNELS) begin
         beat_next = S_FCS;
      end else begin
         beat_next = S_TAIL;
      end
   end

   // Tail word: remaining FCS bytes, then Terminate, then Idle fill.
   always_comb begin
      fcs_cur   = ~crc_q;
      pad_crc   = crc_update(crc_q, '0, '1);
      tail_word = '0;
      tail_ctrl = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (i < int'(tail_n_q)) begin
            tail_word[W_BYTE*i +: W_BYTE] = fcs_cur[W_BYTE*(N_CHANNELS - int'(tail_n_q) + i) +: W_BYTE];
         end else if (i == int'(tail_n_q)) begin
            tail_word[W_BYTE*i +: W_BYTE] = C_TERM;
            tail_ctrl[i] = 1'b1;
         end else begin
            tail_word[W_BYTE*i +: W_BYTE] = C_IDLE;
            tail_ctrl[i] = 1'b1;
         end
      end
   end

   // Frame sequencer with registered write-port outputs; everything holds while i_clk_en is low.
   always_ff @(posedge i_clk) begin
      if (i_reset || (i_clk_en && i_clr)) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         crc_q      <= 32'hFFFFFFFF;
         tail_n_q   <= '0;
         ifg_q      <= '0;
         wen_q      <= 1'b0;
         wctrl_q    <= '0;
         wdata_q    <= '0;
         underrun_q <= 1'b0;
      end else if (i_clk_en) begin
         wen_q      <= 1'b0;
         wctrl_q    <= '0;
         wdata_q    <= '0;
         underrun_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_tvalid) state_q <= S_PRE0;
            end
            S_PRE0: begin
               wen_q   <= 1'b1;
               wctrl_q <= N_CHANNELS'(1);
               wdata_q <= PRE0_WORD;
               state_q <= S_PRE1;
            end
            S_PRE1: begin
               wen_q   <= 1'b1;
               wdata_q <= PRE1_WORD;
               state_q <= S_DATA;
            end
            S_DATA: begin
               if (i_tvalid) begin
                  wen_q    <= 1'b1;
                  wdata_q  <= beat_word;
                  crc_q    <= beat_crc;
                  count_q  <= beat_count;
                  tail_n_q <= beat_n;
                  state_q  <= beat_next;
               end else begin
                  underrun_q <= 1'b1;
               end
            end
            S_PAD: begin
               wen_q   <= 1'b1;
               crc_q   <= pad_crc;
               count_q <= sat_add(count_q, W_N'(N_CHANNELS));
               if (({1'b0, count_q} + 17'(N_CHANNELS)) >= 17'(MIN_PAYLOAD)) state_q <= S_FCS;
            end
            S_FCS: begin
               wen_q   <= 1'b1;
               wdata_q <= fcs_cur[W_WORD-1:0];
               state_q <= S_TERM;
            end
            S_TAIL: begin
               wen_q   <= 1'b1;
               wctrl_q <= tail_ctrl;
               wdata_q <= tail_word;
               state_q <= S_IFG;
            end
            S_TERM: begin
               wen_q   <= 1'b1;
               wctrl_q <= '1;
               wdata_q <= TERM_WORD;
               state_q <= S_IFG;
            end
            S_IFG: begin
               wen_q   <= 1'b1;
               wctrl_q <= '1;
               wdata_q <= IDLE_WORD;
               if (ifg_q == W_IFG'(IFG_WORDS - 1)) begin
                  ifg_q   <= '0;
                  crc_q   <= 32'hFFFFFFFF;
                  count_q <= '0;
                  state_q <= S_IDLE;
               end else begin
                  ifg_q <= ifg_q + W_IFG'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_wen      = wen_q;
   assign o_wctrl    = wctrl_q;
   assign o_wdata    = wdata_q;
   assign o_underrun = underrun_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: directed vector table, hand-written clear/reset sequences, randomized frames.
// Expected lane words come from a byte-stream model of the frame (preamble, padded payload, FCS, T, idles).
module tb_mac_tx_framer;
   localparam int N       = 4;
   localparam int MIN_PAY = 60;
   localparam int IFG     = 3;

   logic        i_clk, i_reset, i_clk_en, i_clr, i_tvalid, o_tready, i_tlast;
   logic        o_wen, o_underrun;
   logic [31:0] i_tdata, o_wdata;
   logic [3:0]  i_tkeep, o_wctrl;

   mac_tx_framer #(.N_CHANNELS(N), .W_BYTE(8), .MIN_PAYLOAD(MIN_PAY), .IFG_WORDS(IFG)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_clr(i_clr),
      .i_tvalid(i_tvalid), .o_tready(o_tready), .i_tdata(i_tdata), .i_tkeep(i_tkeep),
      .i_tlast(i_tlast), .o_wen(o_wen), .o_wctrl(o_wctrl), .o_wdata(o_wdata),
      .o_underrun(o_underrun)
   );

   typedef struct {
      int         len;
      int         start;
      int         gap_at;
      int         gap_len;
      int         mode;
      int         exp_writes;
      int         exp_und;
      int         exp_trdy;
      logic [3:0] exp_end_ctrl;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          en_mode  = 0;
   int          n_und    = 0;
   int          n_trdy   = 0;
   logic [35:0] got_q[$];
   logic [35:0] exp_q[$];
   logic [7:0]  pay[$];

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Clock-enable pattern: 0 = always on, 1 = alternating, 2 = random.
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (en_mode == 0)      i_clk_en = 1'b1;
         else if (en_mode == 1) i_clk_en = ~i_clk_en;
         else                   i_clk_en = 1'($urandom_range(0, 1));
      end
   end

   // Buffer-side view: a word is written when o_wen is high at an enabled edge.
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_clk_en && o_wen)      got_q.push_back({o_wctrl, o_wdata});
         if (i_clk_en && o_underrun) n_und++;
         if (i_clk_en && o_tready)   n_trdy++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Serialize the whole frame as a lane-byte stream, then cut it into words.
   function automatic void build_expected();
      logic [7:0]  fb[$];
      logic [8:0]  ls[$];
      logic [31:0] crc;
      logic [35:0] w;
      fb = pay;
      while (fb.size() < MIN_PAY) fb.push_back(8'h00);
      crc = 32'hFFFFFFFF;
      foreach (fb[i]) crc = crc32_byte(crc, fb[i]);
      crc = ~crc;
      for (int k = 0; k < 4; k++) fb.push_back(crc[8*k +: 8]);
      ls.push_back({1'b1, 8'hFB});
      repeat (6) ls.push_back({1'b0, 8'h55});
      ls.push_back({1'b0, 8'hD5});
      foreach (fb[i]) ls.push_back({1'b0, fb[i]});
      ls.push_back({1'b1, 8'hFD});
      while (ls.size() % N != 0) ls.push_back({1'b1, 8'h07});
      repeat (IFG * N) ls.push_back({1'b1, 8'h07});
      exp_q.delete();
      for (int wi = 0; wi < ls.size() / N; wi++) begin
         w = '0;
         for (int l = 0; l < N; l++) begin
            w[32+l]    = ls[N*wi+l][8];
            w[8*l +: 8] = ls[N*wi+l][7:0];
         end
         exp_q.push_back(w);
      end
   endfunction

   task automatic run_frame(input string tag, input int gap_at, input int gap_len, input int mode,
                            output int writes, output int und, output int trdy);
      int   nb, b, gl, cyc, len, nv, mm;
      logic acc;
      len = pay.size();
      nb  = (len + N - 1) / N;
      build_expected();
      en_mode = mode;
      got_q.delete();
      n_und  = 0;
      n_trdy = 0;
      b = 0; gl = gap_len; cyc = 0;
      while (b < nb && cyc < 4000) begin
         if (b == gap_at && gl > 0) begin
            i_tvalid = 1'b0;
         end else begin
            i_tvalid = 1'b1;
            i_tlast  = (b == nb - 1);
            nv = i_tlast ? len - N*b : N;
            for (int l = 0; l < N; l++) begin
               if (l < nv) i_tdata[8*l +: 8] = pay[N*b+l];
               else        i_tdata[8*l +: 8] = 8'($urandom);
            end
            i_tkeep = i_tlast ? 4'((1 << nv) - 1) : 4'($urandom);
         end
         @(negedge i_clk);
         acc = i_tvalid && o_tready && i_clk_en;
         if (!i_tvalid && o_tready && i_clk_en) gl--;
         @(posedge i_clk);
         #1;
         if (acc) b++;
         cyc++;
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      check({tag, ":beats"}, 64'(b), 64'(nb));
      cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < 4000) begin
         @(posedge i_clk);
         cyc++;
      end
      repeat (8) @(posedge i_clk);
      #1;
      writes = got_q.size();
      und    = n_und;
      trdy   = n_trdy;
      check({tag, ":nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
      mm = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) begin
            mm = i;
            break;
         end
      end
      n_checks++;
      if (mm >= 0) begin
         n_fail++;
         $display("FAIL %s:words idx=%0d got=%h exp=%h", tag, mm, got_q[mm], exp_q[mm]);
      end
   endtask

   task automatic accept_one_beat();
      int   cyc;
      logic ok;
      i_tvalid = 1'b1; i_tdata = 32'h44332211; i_tkeep = 4'hF; i_tlast = 1'b0;
      ok = 1'b0; cyc = 0;
      while (!ok && cyc < 20) begin
         @(negedge i_clk);
         ok = o_tready && i_clk_en;
         @(posedge i_clk);
         #1;
         cyc++;
      end
      check("hand_accept", 64'(ok), 64'd1);
   endtask

   initial begin
      vec_t vt [0:10];
      int   w, u, t;
      logic [3:0] endc, prec;
      i_reset = 1'b1; i_clk_en = 1'b1; i_clr = 1'b0; i_tvalid = 1'b0;
      i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0;

      //         len start gap_at gap_len mode writes und trdy end_ctrl
      vt[0]  = '{60,  'h00, 0, 0, 0, 22, 0, 15, 4'b1111};
      vt[1]  = '{1,   'hAB, 0, 0, 0, 22, 0, 1,  4'b1111};
      vt[2]  = '{62,  'h00, 0, 0, 0, 22, 0, 16, 4'b1100};
      vt[3]  = '{60,  'h00, 5, 3, 0, 22, 3, 18, 4'b1111};
      vt[4]  = '{60,  'h00, 0, 0, 1, 22, 0, 15, 4'b1111};
      vt[5]  = '{64,  'h10, 0, 0, 0, 23, 0, 16, 4'b1111};
      vt[6]  = '{63,  'h20, 0, 0, 0, 22, 0, 16, 4'b1000};
      vt[7]  = '{61,  'h30, 0, 0, 0, 22, 0, 16, 4'b1110};
      vt[8]  = '{57,  'h40, 0, 0, 0, 22, 0, 15, 4'b1111};
      vt[9]  = '{100, 'h50, 7, 2, 1, 32, 2, 27, 4'b1111};
      vt[10] = '{4,   'hC0, 0, 0, 2, 22, 0, 1,  4'b1111};

      repeat (3) @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(negedge i_clk);
      check("rst_wen",      64'(o_wen),      64'd0);
      check("rst_wctrl",    64'(o_wctrl),    64'd0);
      check("rst_wdata",    64'(o_wdata),    64'd0);
      check("rst_underrun", 64'(o_underrun), 64'd0);
      check("rst_tready",   64'(o_tready),   64'd0);
      @(posedge i_clk);
      #1;

      for (int v = 0; v < 11; v++) begin
         pay.delete();
         for (int i = 0; i < vt[v].len; i++) pay.push_back(8'(vt[v].start + i));
         run_frame($sformatf("vec%0d", v), vt[v].gap_at, vt[v].gap_len, vt[v].mode, w, u, t);
         endc = (got_q.size() > IFG) ? got_q[got_q.size()-1-IFG][35:32] : 4'h0;
         prec = (got_q.size() > 0) ? got_q[0][35:32] : 4'h0;
         check($sformatf("vec%0d:writes", v),   64'(w),    64'(vt[v].exp_writes));
         check($sformatf("vec%0d:underrun", v), 64'(u),    64'(vt[v].exp_und));
         check($sformatf("vec%0d:tready", v),   64'(t),    64'(vt[v].exp_trdy));
         check($sformatf("vec%0d:end_ctrl", v), 64'(endc), 64'(vt[v].exp_end_ctrl));
         check($sformatf("vec%0d:pre0_ctrl", v), 64'(prec), 64'(4'b0001));
      end

      // Synchronous reset in the middle of DATA.
      en_mode = 0;
      @(posedge i_clk);
      #1;
      accept_one_beat();
      check("pre_reset_wen", 64'(o_wen), 64'd1);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0; i_tvalid = 1'b0;
      @(negedge i_clk);
      check("midrst_wen",    64'(o_wen),    64'd0);
      check("midrst_wdata",  64'(o_wdata),  64'd0);
      check("midrst_tready", 64'(o_tready), 64'd0);
      @(posedge i_clk);
      #1;

      // Abort in DATA after a stall, then a clean frame with a fresh CRC.
      accept_one_beat();
      i_tvalid = 1'b0;
      @(posedge i_clk);
      #1;
      check("stall_underrun", 64'(o_underrun), 64'd1);
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr = 1'b0;
      @(negedge i_clk);
      check("clr_wen",      64'(o_wen),      64'd0);
      check("clr_underrun", 64'(o_underrun), 64'd0);
      check("clr_tready",   64'(o_tready),   64'd0);
      @(posedge i_clk);
      #1;
      pay.delete();
      for (int i = 0; i < 60; i++) pay.push_back(8'(8'h80 + i));
      run_frame("after_clr", 0, 0, 0, w, u, t);
      check("after_clr:writes", 64'(w), 64'd22);

      // Randomized frames against the byte-stream model.
      for (int r = 0; r < 20; r++) begin
         int len, nb, ga, gln, md;
         len = $urandom_range(1, 90);
         nb  = (len + N - 1) / N;
         pay.delete();
         repeat (len) pay.push_back(8'($urandom));
         gln = (nb > 1) ? $urandom_range(0, 3) : 0;
         ga  = (nb > 1) ? $urandom_range(1, nb - 1) : 0;
         md  = $urandom_range(0, 2);
         run_frame($sformatf("rnd%0d", r), ga, gln, md, w, u, t);
         check($sformatf("rnd%0d:underrun", r), 64'(u), 64'(gln));
         check($sformatf("rnd%0d:tready", r),   64'(t), 64'(nb + gln));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
- Upstream neighbour of the MAC TX buffer.
- Accepts a user payload stream 4 bytes per beat. Emits XGMII-style lane words (per-lane ctrl bit plus data byte) into the buffer write port.
- Each frame is emitted as: Start/preamble/SFD, payload, zero padding up to the minimum size, IEEE 802.3 FCS, Terminate, then inter-frame-gap idles.
- All state advances only on enabled clock cycles.

Parameters:
- N_CHANNELS, 4, byte lanes per word. Lane 0 is transmitted first.
- W_BYTE, 8, bits per lane.
- MIN_PAYLOAD, 60, minimum bytes before the FCS. Must be a multiple of N_CHANNELS.
- IFG_WORDS, 3, full idle words written after the Terminate word.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_clk_en  in  1  clock enable; state, counters and outputs update only when 1
- i_clr  in  1  synchronous abort; FSM to IDLE, in-progress frame dropped
- i_tvalid  in  1  payload beat valid
- o_tready  out  1  framer accepts the beat this cycle
- i_tdata  in  N_CHANNELS*W_BYTE  payload; lane 0 = first byte
- i_tkeep  in  N_CHANNELS  contiguous from lane 0; must be all-ones except on the last beat
- i_tlast  in  1  last payload beat
- o_wen  out  1  buffer write strobe
- o_wctrl  out  N_CHANNELS  per-lane control flag
- o_wdata  out  N_CHANNELS*W_BYTE  lane bytes
- o_underrun  out  1  one-cycle pulse per enabled cycle stalled in DATA with i_tvalid=0

Behaviour:
- Reset, also i_clr when i_clk_en=1:
  - FSM=IDLE, byte count=0, CRC=32'hFFFFFFFF.
  - o_wen=0, o_wctrl=0, o_wdata=0, o_underrun=0.
  - o_tready=0.
- Outputs are registered. The word produced in state S appears on o_w* the enabled cycle after S is evaluated.
- A beat transfers when i_tvalid & o_tready & i_clk_en. o_tready is combinational: 1 only in DATA.
- Control characters (ctrl=1): Start 0xFB, Terminate 0xFD, Idle 0x07. All other lanes have ctrl=0.
- CRC-32, poly 0x04C11DB7, reflected:
  - Init 0xFFFFFFFF, updated per accepted byte (data and pad bytes).
  - FCS = ~CRC, transmitted byte0 = FCS[7:0] first.
- Byte count is 16 bits and saturates at 0xFFFF.
- FSM:
  - IDLE: o_wen=0. If i_tvalid, go to PRE0. The beat is not consumed.
  - PRE0: write {0x55,0x55,0x55,0xFB}, lane0 = Start ctrl. Go to PRE1.
  - PRE1: write {0xD5,0x55,0x55,0x55} with lane0=0x55, ctrl=0. Go to DATA.
  - DATA: write the accepted beat and add valid-lane count to byte count.
    - Last beat, count < MIN_PAYLOAD: invalid lanes are zero-filled (counted as pad). Go to PAD, or to FCS if count reaches MIN_PAYLOAD.
    - Last beat, count ≥ MIN_PAYLOAD with n valid lanes: if n=4, go to FCS. If n<4, lanes n..3 carry FCS bytes 0..3-n and the FSM goes to TAIL.
    - i_tvalid=0: no write, pulse o_underrun, stay in DATA.
  - PAD: write zero words, 4 bytes each, until count=MIN_PAYLOAD. Go to FCS.
  - FCS: write FCS bytes 0..3. Go to TERM.
  - TAIL: write the remaining n FCS bytes in lanes 0..n-1, Terminate in lane n, Idle in lanes above. Go to IFG.
  - TERM: write {I,I,I,T} with lane0=Terminate. Go to IFG.
  - IFG: write all-Idle words, IFG_WORDS of them. Then reset CRC and count and go to IDLE.
- i_clk_en=0: nothing changes. o_wen keeps its value but the buffer ignores it because the buffer is gated by the same enable.
- Back-to-back frames: the next frame may start in the IDLE cycle immediately after IFG. Minimum gap ≥ 12 idle bytes.
- i_tkeep is ignored unless i_tlast=1. A single-beat frame (i_tlast on the first beat) is legal.
- The framer never stalls for the buffer. Buffer sizing is the system's responsibility.

Test Plan:
- 60-byte payload of 0x00..0x3B, single frame:
  - Required output: PRE0 word with o_wctrl=4'b0001; PRE1 word; 15 data words; FCS word equal to the bench CRC model; TERM word with o_wctrl=4'b1111 and lane0=0xFD; 3 idle words.
  - Total 22 writes, and o_tready high for exactly 15 cycles.
- 1-byte payload 0xAB with i_tkeep=4'b0001: data word {00,00,00,AB}, then 14 pad words, FCS, TERM, IFG.
- 62-byte payload, last i_tkeep=4'b0011: last data word carries FCS bytes 0-1 in lanes 2-3. TAIL word carries FCS bytes 2-3 in lanes 0-1, 0xFD in lane 2 with ctrl, Idle in lane 3; o_wctrl=4'b1100.
- i_tvalid dropped for 3 cycles mid-frame: 3 o_underrun pulses, no writes in that gap, frame bytes and FCS unchanged versus the no-gap run.
- i_clk_en toggling 1/0 during a frame: output word sequence identical to the run with i_clk_en=1; no duplicated or lost words.
- i_clr asserted in the DATA state: next enabled cycle o_wen=0 and FSM=IDLE. A following frame starts with PRE0 and its FCS is correct (CRC re-initialised).
